bf16_mult_pipe: RTL and testbench

//   Multi-lane, 3-stage pipelined BF16 x BF16 -> FP32 multiplier with valid/ready handshake.

---
 rtl/bf16_mult_pkg.sv | 38 +++
 rtl/bf16_mult_pipe_lane.sv | 187 ++++++++++++++++++
 rtl/bf16_mult_pipe.sv | 85 ++++++++
 tb/tb_bf16_mult_pipe.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bf16_mult_pkg.sv
// Shared constants, operand classes and result kinds for the pipelined BF16 x BF16 -> FP32 multiplier.
package bf16_mult_pkg;

  localparam int BF16_EXP_W = 8;
  localparam int BF16_MAN_W = 7;
  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;
  localparam int EXP_BIAS   = 127;

  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

  // Flag vector per lane is {invalid, overflow, underflow}
  localparam int FLAG_INVALID   = 2;
  localparam int FLAG_OVERFLOW  = 1;
  localparam int FLAG_UNDERFLOW = 0;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_SUB,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } fp_class_e;

  typedef enum logic [1:0] {
    RES_NUM,
    RES_NAN,
    RES_INF,
    RES_ZERO
  } res_kind_e;

  function automatic fp_class_e classify(input logic [15:0] x);
    if (x[14:7] == 8'h00) return (x[6:0] == 7'd0) ? CLS_ZERO : CLS_SUB;
    if (x[14:7] == 8'hFF) return (x[6:0] == 7'd0) ? CLS_INF : CLS_NAN;
    return CLS_NORM;
  endfunction

endpackage

// File: rtl/bf16_mult_pipe_lane.sv
// One multiplier lane: S1 unpack/classify, S2 mantissa product + exponent sum, S3 normalise/pack.
// Optional subnormal support is selected with the BF16_MULT_DENORM_EN macro.
module bf16_mult_lane
  import bf16_mult_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_en1,
  input  logic        i_en2,
  input  logic        i_en3,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [31:0] o_p,
  output logic [2:0]  o_flags
);

  // ---------------- S1: unpack / classify ----------------
  fp_class_e  w_cls_a, w_cls_b;
  logic [7:0] w_exp_a, w_exp_b;
  logic [7:0] w_man_a, w_man_b;

  assign w_cls_a = classify(i_a);
  assign w_cls_b = classify(i_b);
  // Subnormals sit at exponent 1 with a clear hidden bit
  assign w_exp_a = (w_cls_a == CLS_SUB) ? 8'd1 : i_a[14:7];
  assign w_exp_b = (w_cls_b == CLS_SUB) ? 8'd1 : i_b[14:7];
  assign w_man_a = {(w_cls_a == CLS_NORM), i_a[6:0]};
  assign w_man_b = {(w_cls_b == CLS_NORM), i_b[6:0]};

  logic       r_s1_sign;
  fp_class_e  r_s1_cls_a, r_s1_cls_b;
  logic [7:0] r_s1_exp_a, r_s1_exp_b;
  logic [7:0] r_s1_man_a, r_s1_man_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_sign  <= 1'b0;
      r_s1_cls_a <= CLS_ZERO;
      r_s1_cls_b <= CLS_ZERO;
      r_s1_exp_a <= 8'd0;
      r_s1_exp_b <= 8'd0;
      r_s1_man_a <= 8'd0;
      r_s1_man_b <= 8'd0;
    end else if (i_en1) begin
      r_s1_sign  <= i_a[15] ^ i_b[15];
      r_s1_cls_a <= w_cls_a;
      r_s1_cls_b <= w_cls_b;
      r_s1_exp_a <= w_exp_a;
      r_s1_exp_b <= w_exp_b;
      r_s1_man_a <= w_man_a;
      r_s1_man_b <= w_man_b;
    end
  end

  // ---------------- S2: special decode, multiply, exponent sum ----------------
  logic             w_zero_a, w_zero_b, w_inf_a, w_inf_b, w_nan_any, w_flush;
  res_kind_e        w_kind;
  logic [15:0]      w_prod;
  logic signed [9:0] w_esum;

`ifdef BF16_MULT_DENORM_EN
  assign w_zero_a = (r_s1_cls_a == CLS_ZERO);
  assign w_zero_b = (r_s1_cls_b == CLS_ZERO);
  assign w_flush  = 1'b0;
`else
  assign w_zero_a = (r_s1_cls_a == CLS_ZERO) || (r_s1_cls_a == CLS_SUB);
  assign w_zero_b = (r_s1_cls_b == CLS_ZERO) || (r_s1_cls_b == CLS_SUB);
  assign w_flush  = (r_s1_cls_a == CLS_SUB) || (r_s1_cls_b == CLS_SUB);
`endif
  assign w_inf_a   = (r_s1_cls_a == CLS_INF);
  assign w_inf_b   = (r_s1_cls_b == CLS_INF);
  assign w_nan_any = (r_s1_cls_a == CLS_NAN) || (r_s1_cls_b == CLS_NAN) ||
                     (w_inf_a && w_zero_b) || (w_zero_a && w_inf_b);

  always_comb begin
    w_kind = RES_NUM;
    if (w_nan_any)                w_kind = RES_NAN;
    else if (w_inf_a || w_inf_b)  w_kind = RES_INF;
    else if (w_zero_a || w_zero_b) w_kind = RES_ZERO;
  end

  assign w_prod = {8'd0, r_s1_man_a} * {8'd0, r_s1_man_b};
  assign w_esum = $signed({2'b00, r_s1_exp_a}) + $signed({2'b00, r_s1_exp_b}) - 10'sd127;

  logic              r_s2_sign;
  res_kind_e         r_s2_kind;
  logic              r_s2_flush;
  logic [15:0]       r_s2_prod;
  logic signed [9:0] r_s2_esum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_sign  <= 1'b0;
      r_s2_kind  <= RES_ZERO;
      r_s2_flush <= 1'b0;
      r_s2_prod  <= 16'd0;
      r_s2_esum  <= 10'sd0;
    end else if (i_en2) begin
      r_s2_sign  <= r_s1_sign;
      r_s2_kind  <= w_kind;
      r_s2_flush <= w_flush;
      r_s2_prod  <= w_prod;
      r_s2_esum  <= w_esum;
    end
  end

  // ---------------- S3: normalise / pack ----------------
  logic signed [9:0] w_exp;
  logic [22:0]       w_frac;

`ifdef BF16_MULT_DENORM_EN
  logic [3:0]        w_lz;
  logic [15:0]       w_norm;
  logic [23:0]       w_sig;
  logic signed [9:0] w_shamt;
  logic [22:0]       w_sub;

  always_comb begin
    w_lz = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (r_s2_prod[i]) w_lz = 4'(15 - i);
    end
  end

  assign w_norm  = r_s2_prod << w_lz;
  assign w_exp   = r_s2_esum + 10'sd1 - $signed({6'd0, w_lz});
  assign w_frac  = {w_norm[14:0], 8'd0};
  assign w_sig   = {w_norm, 8'd0};
  // Denormalising shift truncates, i.e. rounds toward zero
  assign w_shamt = 10'sd1 - w_exp;
  assign w_sub   = (w_shamt >= 10'sd24) ? 23'd0 : 23'(w_sig >> w_shamt[4:0]);
`else
  assign w_exp  = r_s2_esum + $signed({9'd0, r_s2_prod[15]});
  assign w_frac = r_s2_prod[15] ? {r_s2_prod[14:0], 8'd0} : {r_s2_prod[13:0], 9'd0};
`endif

  logic [31:0] w_p_next;
  logic [2:0]  w_f_next;

  always_comb begin
    w_p_next = 32'd0;
    w_f_next = 3'b000;
    case (r_s2_kind)
      RES_NAN: begin
        w_p_next               = FP32_QNAN;
        w_f_next[FLAG_INVALID] = 1'b1;
      end
      RES_INF:  w_p_next = {r_s2_sign, 8'hFF, 23'd0};
      RES_ZERO: begin
        w_p_next                 = {r_s2_sign, 31'd0};
        w_f_next[FLAG_UNDERFLOW] = r_s2_flush;
      end
      default: begin
        if (w_exp >= 10'sd255) begin
          w_p_next                = {r_s2_sign, 8'hFF, 23'd0};
          w_f_next[FLAG_OVERFLOW] = 1'b1;
        end else if (w_exp <= 10'sd0) begin
`ifdef BF16_MULT_DENORM_EN
          w_p_next = {r_s2_sign, 8'h00, w_sub};
`else
          w_p_next = {r_s2_sign, 31'd0};
`endif
          w_f_next[FLAG_UNDERFLOW] = 1'b1;
        end else begin
          w_p_next = {r_s2_sign, w_exp[7:0], w_frac};
        end
      end
    endcase
  end

  logic [31:0] r_p;
  logic [2:0]  r_flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p     <= 32'd0;
      r_flags <= 3'b000;
    end else if (i_en3) begin
      r_p     <= w_p_next;
      r_flags <= w_f_next;
    end
  end

  assign o_p     = r_p;
  assign o_flags = r_flags;

endmodule

// File: rtl/bf16_mult_pipe.sv
// LANES-wide 3-stage BF16 x BF16 -> FP32 multiplier with valid/ready handshake and sideband tag.
// Define BF16_MULT_DENORM_EN to enable subnormal inputs/outputs (default flushes them to zero).
module bf16_mult_pipe
  import bf16_mult_pkg::*;
#(
  parameter int LANES = 4,
  parameter int TAG_W = 8
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [16*LANES-1:0] in_a,
  input  logic [16*LANES-1:0] in_b,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [32*LANES-1:0] out_p,
  output logic [TAG_W-1:0]    out_tag,
  output logic [3*LANES-1:0]  out_flags,
  output logic                busy
);

  logic r_v1, r_v2, r_v3;
  logic w_adv1, w_adv2, w_adv3;
  logic w_en1, w_en2, w_en3;

  // Ready ripples back combinationally so a full pipe still streams at 1 beat/cycle
  assign w_adv3 = out_ready || !r_v3;
  assign w_adv2 = !r_v2 || w_adv3;
  assign w_adv1 = !r_v1 || w_adv2;

  // Data registers only load real beats, so bubbles leave them untouched
  assign w_en1 = w_adv1 && in_valid;
  assign w_en2 = w_adv2 && r_v1;
  assign w_en3 = w_adv3 && r_v2;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else begin
      if (w_adv1) r_v1 <= in_valid;
      if (w_adv2) r_v2 <= r_v1;
      if (w_adv3) r_v3 <= r_v2;
    end
  end

  logic [TAG_W-1:0] r_tag1, r_tag2, r_tag3;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_tag1 <= '0;
      r_tag2 <= '0;
      r_tag3 <= '0;
    end else begin
      if (w_en1) r_tag1 <= in_tag;
      if (w_en2) r_tag2 <= r_tag1;
      if (w_en3) r_tag3 <= r_tag2;
    end
  end

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      bf16_mult_lane u_lane (
        .clk     (CLK),
        .rst_n   (RSTn),
        .i_en1   (w_en1),
        .i_en2   (w_en2),
        .i_en3   (w_en3),
        .i_a     (in_a[16*gi +: 16]),
        .i_b     (in_b[16*gi +: 16]),
        .o_p     (out_p[32*gi +: 32]),
        .o_flags (out_flags[3*gi +: 3])
      );
    end
  endgenerate

  assign in_ready  = w_adv1;
  assign out_valid = r_v3;
  assign out_tag   = r_tag3;
  assign busy      = r_v1 || r_v2 || r_v3;

endmodule

// File: tb/tb_bf16_mult_pipe.sv
// Self-checking bench for bf16_mult_pipe: directed specials, stall/backpressure, randomized stream
// against a value-level reference model, and mid-flight reset.
module tb_bf16_mult_pipe;

  localparam int LANES = 4;
  localparam int TAG_W = 8;
  localparam int N_RAND = 10000;

  logic                CLK = 1'b0;
  logic                RSTn = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [16*LANES-1:0] in_a = '0;
  logic [16*LANES-1:0] in_b = '0;
  logic [TAG_W-1:0]    in_tag = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [32*LANES-1:0] out_p;
  logic [TAG_W-1:0]    out_tag;
  logic [3*LANES-1:0]  out_flags;
  logic                busy;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [32*LANES-1:0] p;
    logic [3*LANES-1:0]  f;
    logic [TAG_W-1:0]    tag;
  } beat_t;

  beat_t exp_q[$];

  bf16_mult_pipe #(.LANES(LANES), .TAG_W(TAG_W)) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_tag   (out_tag),
    .out_flags (out_flags),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  // Reference: treat each operand as integer significand * 2^exponent and scale the exact product.
  // Returns {invalid, overflow, underflow, fp32}.
  function automatic logic [34:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    int     ea, eb, msb, e, k;
    longint siga, sigb, prod, m;
    bit     s, za, zb, ia, ib, na, nb, uf_in;
    logic [22:0] frac;
    s  = a[15] ^ b[15];
    ea = int'(a[14:7]);
    eb = int'(b[14:7]);
    na = (ea == 255) && (a[6:0] != 0);
    nb = (eb == 255) && (b[6:0] != 0);
    ia = (ea == 255) && (a[6:0] == 0);
    ib = (eb == 255) && (b[6:0] == 0);
    za = (ea == 0) && (a[6:0] == 0);
    zb = (eb == 0) && (b[6:0] == 0);
    uf_in = 0;
`ifndef BF16_MULT_DENORM_EN
    if (ea == 0 && a[6:0] != 0) begin za = 1; uf_in = 1; end
    if (eb == 0 && b[6:0] != 0) begin zb = 1; uf_in = 1; end
`endif
    siga = (ea == 0) ? longint'(a[6:0]) : longint'(128 + a[6:0]);
    sigb = (eb == 0) ? longint'(b[6:0]) : longint'(128 + b[6:0]);
    if (ea == 0) ea = 1;
    if (eb == 0) eb = 1;
    if (na || nb || (ia && zb) || (za && ib)) return {3'b100, 32'h7FC0_0000};
    if (ia || ib) return {3'b000, s, 8'hFF, 23'd0};
    if (za || zb) return {2'b00, uf_in, s, 31'd0};
    // value = prod * 2^(ea+eb-254-14)
    prod = siga * sigb;
    msb = 0;
    while ((prod >> (msb + 1)) != 0) msb++;
    e = ea + eb - 268 + msb + 127;
    if (e >= 255) return {3'b010, s, 8'hFF, 23'd0};
    if (e >= 1) begin
      frac = 23'((prod << (23 - msb)) & 64'h7F_FFFF);
      return {3'b000, s, 8'(e), frac};
    end
`ifdef BF16_MULT_DENORM_EN
    // count of 2^-149 units, truncated
    k = ea + eb - 119;
    if (k >= 0) m = prod << k;
    else if (-k >= 63) m = 0;
    else m = prod >> (-k);
    return {3'b001, s, 8'h00, 23'(m)};
`else
    k = 0;
    m = 0;
    return {3'b001, s, 31'd0};
`endif
  endfunction

  function automatic beat_t ref_beat(input logic [16*LANES-1:0] a, input logic [16*LANES-1:0] b,
                                     input logic [TAG_W-1:0] tag);
    beat_t r;
    logic [34:0] l;
    for (int i = 0; i < LANES; i++) begin
      l = ref_mul(a[16*i +: 16], b[16*i +: 16]);
      r.p[32*i +: 32] = l[31:0];
      r.f[3*i +: 3]   = l[34:32];
    end
    r.tag = tag;
    return r;
  endfunction

  function automatic logic [15:0] rand_op();
    logic [15:0] specials [10];
    specials = '{16'h0000, 16'h8000, 16'h7F80, 16'hFF80, 16'h7FC0,
                 16'h0001, 16'h807F, 16'h7F7F, 16'h0080, 16'h3F80};
    if ($urandom_range(0, 7) == 0) return specials[$urandom_range(0, 9)];
    return 16'($urandom);
  endfunction

  function automatic logic [16*LANES-1:0] rand_bus();
    logic [16*LANES-1:0] v;
    for (int i = 0; i < LANES; i++) v[16*i +: 16] = rand_op();
    return v;
  endfunction

  task automatic test_reset();
    RSTn = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL reset_valid_busy: got out_valid=%0b busy=%0b want 0 0", out_valid, busy);
    end
    checks++;
    if ({out_p, out_tag, out_flags} !== '0) begin
      errors++; $display("FAIL reset_outputs: got p=%h tag=%h flags=%h want all zero", out_p, out_tag, out_flags);
    end
    @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready);
    end
    $display("reset: out_valid=%0b busy=%0b in_ready=%0b", out_valid, busy, in_ready);
  endtask

  task automatic test_directed();
    beat_t exp_a, exp_b, got;
    exp_a.p   = {32'h7FC0_0000, 32'h7F80_0000, 32'h4010_0000, 32'h4000_0000};
    exp_a.f   = {3'b100, 3'b010, 3'b000, 3'b000};
    exp_a.tag = 8'hA1;
`ifdef BF16_MULT_DENORM_EN
    exp_b.p   = {32'h0000_0000, 32'h8000_0000, 32'h0001_0000, 32'h7FC0_0000};
`else
    exp_b.p   = {32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 32'h7FC0_0000};
`endif
    exp_b.f   = {3'b001, 3'b000, 3'b001, 3'b100};
    exp_b.tag = 8'hB2;
    out_ready = 1'b1;
    @(negedge CLK);
    in_valid = 1'b1;
    in_a = {16'h7F80, 16'h7F7F, 16'h3FC0, 16'h3F80};
    in_b = {16'h0000, 16'h7F7F, 16'h3FC0, 16'h4000};
    in_tag = 8'hA1;
    @(posedge CLK);                      // beat A captured (edge 1)
    @(negedge CLK);
    in_a = {16'h0080, 16'h8000, 16'h0001, 16'hFFC1};
    in_b = {16'h0080, 16'h3F80, 16'h3F80, 16'h3F80};
    in_tag = 8'hB2;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL dir_latency_e1: got out_valid=%0b want 0", out_valid);
    end
    @(posedge CLK);                      // edge 2
    @(negedge CLK);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL dir_latency_e2: got out_valid=%0b want 0", out_valid);
    end
    @(posedge CLK);                      // edge 3: beat A at outputs
    @(negedge CLK);
    #1;
    got = {out_p, out_flags, out_tag};
    checks++;
    if ({out_valid, got} !== {1'b1, exp_a}) begin
      errors++; $display("FAIL dir_beat_a: got v=%0b %h want v=1 %h", out_valid, got, exp_a);
    end
    $display("directed A: tag=%h p=%h flags=%h", out_tag, out_p, out_flags);
    @(posedge CLK);
    @(negedge CLK);
    #1;
    got = {out_p, out_flags, out_tag};
    checks++;
    if ({out_valid, got} !== {1'b1, exp_b}) begin
      errors++; $display("FAIL dir_beat_b: got v=%0b %h want v=1 %h", out_valid, got, exp_b);
    end
    $display("directed B: tag=%h p=%h flags=%h", out_tag, out_p, out_flags);
    @(posedge CLK);
    @(negedge CLK);
    #1;
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL dir_drain: got out_valid=%0b busy=%0b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_stall();
    logic [16*LANES-1:0] sa [10];
    logic [16*LANES-1:0] sb [10];
    beat_t held, got, want;
    int sent, recv, cyc;
    bit stalled_prev, saw_full;
    for (int i = 0; i < 10; i++) begin
      sa[i] = rand_bus();
      sb[i] = rand_bus();
    end
    exp_q.delete();
    sent = 0; recv = 0; stalled_prev = 0; saw_full = 0;
    held = '0;
    for (cyc = 0; cyc < 100 && recv < 10; cyc++) begin
      @(negedge CLK);
      out_ready = !(cyc >= 2 && cyc <= 7);
      in_valid  = (sent < 10);
      if (sent < 10) begin
        in_a = sa[sent];
        in_b = sb[sent];
        in_tag = 8'(8'h10 + sent);
      end
      #1;
      got = {out_p, out_flags, out_tag};
      if (stalled_prev) begin
        checks++;
        if ({out_valid, got} !== {1'b1, held}) begin
          errors++; $display("FAIL stall_hold: got v=%0b %h want v=1 %h", out_valid, got, held);
        end
      end
      if (in_valid && !in_ready) begin
        saw_full = 1;
        checks++;
        if (sent - recv != 3) begin
          errors++; $display("FAIL stall_depth: in_ready low with %0d beats held, want 3", sent - recv);
        end
      end
      if (out_valid && out_ready) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        checks++;
        if (got !== want) begin
          errors++; $display("FAIL stall_beat: got %h want %h", got, want);
        end
        $display("stall beat %0d: tag=%h p=%h flags=%h", recv, out_tag, out_p, out_flags);
        recv++;
      end
      stalled_prev = out_valid && !out_ready;
      held = got;
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_beat(in_a, in_b, in_tag));
        sent++;
      end
    end
    @(negedge CLK);
    in_valid = 1'b0;
    checks++;
    if (recv != 10) begin
      errors++; $display("FAIL stall_count: got %0d beats want 10", recv);
    end
    checks++;
    if (!saw_full) begin
      errors++; $display("FAIL stall_backpressure: got in_ready never low want low once pipe full");
    end
  endtask

  task automatic test_random();
    beat_t got, want;
    int sent, recv, cyc;
    bit fired_in;
    exp_q.delete();
    sent = 0; recv = 0; fired_in = 0;
    in_valid = 1'b0;
    for (cyc = 0; cyc < 60000 && recv < N_RAND; cyc++) begin
      @(negedge CLK);
      if (fired_in) in_valid = 1'b0;
      if (!in_valid && sent < N_RAND && $urandom_range(0, 3) != 0) begin
        in_a = rand_bus();
        in_b = rand_bus();
        in_tag = 8'($urandom);
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        got = {out_p, out_flags, out_tag};
        want = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        checks++;
        if (got !== want) begin
          errors++; $display("FAIL rand_beat %0d: got %h want %h", recv, got, want);
        end
        $display("rand beat %0d: tag=%h p=%h flags=%h", recv, out_tag, out_p, out_flags);
        recv++;
      end
      fired_in = in_valid && in_ready;
      if (fired_in) begin
        exp_q.push_back(ref_beat(in_a, in_b, in_tag));
        sent++;
      end
    end
    @(negedge CLK);
    in_valid = 1'b0;
    checks++;
    if (recv != N_RAND) begin
      errors++; $display("FAIL rand_count: got %0d beats want %0d", recv, N_RAND);
    end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      in_valid = 1'b1;
      in_a = rand_bus();
      in_b = rand_bus();
      in_tag = 8'(8'hC0 + i);
    end
    @(negedge CLK);
    in_valid = 1'b0;
    #1;
    checks++;
    if ({busy, out_valid} !== 2'b11) begin
      errors++; $display("FAIL midrst_preload: got busy=%0b out_valid=%0b want 1 1", busy, out_valid);
    end
    RSTn = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      errors++; $display("FAIL midrst_async: got out_valid=%0b busy=%0b in_ready=%0b want 0 0 1",
                         out_valid, busy, in_ready);
    end
    checks++;
    if ({out_p, out_tag, out_flags} !== '0) begin
      errors++; $display("FAIL midrst_outputs: got p=%h tag=%h flags=%h want zero", out_p, out_tag, out_flags);
    end
    $display("midflight reset: out_valid=%0b busy=%0b", out_valid, busy);
    @(negedge CLK);
    RSTn = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      #1;
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
        errors++; $display("FAIL midrst_stale cycle %0d: got out_valid=%0b in_ready=%0b want 0 1",
                           i, out_valid, in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_random();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
